// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, token helpers and
// the receive alignment FSM states.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        unique case (c)
            2'b00: t = TOK_C00;
            2'b01: t = TOK_C01;
            2'b10: t = TOK_C10;
            2'b11: t = TOK_C11;
        endcase
        return t;
    endfunction

    function automatic logic is_token(input logic [9:0] w);
        return (w == TOK_C00) || (w == TOK_C01) ||
               (w == TOK_C10) || (w == TOK_C11);
    endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS 10b symbol decode to control or pixel byte.
import tmds_pkg::*;

module tmds_word_decode (
    input  logic [9:0] w,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] d;

    always_comb begin
        is_ctrl = 1'b0;
        ctrl    = 2'b00;
        data    = 8'h00;
        d       = w[9] ? ~w[7:0] : w[7:0];
        for (int c = 0; c < 4; c++) begin
            if (w == ctrl_token(2'(c))) begin
                is_ctrl = 1'b1;
                ctrl    = 2'(c);
            end
        end
        if (!is_ctrl) begin
            data[0] = d[0];
            for (int i = 1; i < 8; i++) begin
                data[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
            end
        end
    end

endmodule

// File: rtl/tmds_rx_decoder.sv
// One TMDS receive channel: token-based word alignment followed
// by a two-stage symbol decode pipeline.
import tmds_pkg::*;

module tmds_rx_decoder #(
    parameter int CTRL_RUN     = 8,
    parameter int LOCK_TIMEOUT = 2048
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_raw,
    input  logic       i_valid,
    output logic       o_valid,
    output logic       o_de,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_locked,
    output logic [3:0] o_offset,
    output logic       o_lock_loss
);

    localparam int RW = $clog2(CTRL_RUN + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    state_t        state_q;
    logic [9:0]    prev_raw;
    logic [19:0]   hist;
    logic [3:0]    off_q;
    logic [RW-1:0] run_q;
    logic [RW-1:0] run_nx;
    logic [TW-1:0] tmo_q;
    logic          loss_q;

    logic          hit;
    logic [3:0]    hit_off;
    logic [9:0]    win_sel;
    logic          lk_hit;

    logic          v1_q;
    logic [9:0]    w1_q;
    logic          m1_q;
    logic          v2_q;
    logic          de_q;
    logic [7:0]    data_q;
    logic [1:0]    ctrl_q;

    logic          dec_is_ctrl;
    logic [1:0]    dec_ctrl;
    logic [7:0]    dec_data;

    assign hist = {i_raw, prev_raw};

    // Scan high-to-low so the lowest matching offset is left standing.
    always_comb begin
        hit     = 1'b0;
        hit_off = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (is_token(hist[k +: 10])) begin
                hit     = 1'b1;
                hit_off = 4'(k);
            end
        end
        win_sel = hist[9:0];
        for (int k = 0; k < 10; k++) begin
            if (off_q == 4'(k)) win_sel = hist[k +: 10];
        end
        lk_hit = is_token(win_sel);
        run_nx = (hit_off == off_q) ? run_q + 1'b1 : RW'(1);
    end

    tmds_word_decode u_dec (
        .w       (w1_q),
        .is_ctrl (dec_is_ctrl),
        .ctrl    (dec_ctrl),
        .data    (dec_data)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= HUNT;
            prev_raw <= '0;
            off_q    <= '0;
            run_q    <= '0;
            tmo_q    <= '0;
            loss_q   <= 1'b0;
            v1_q     <= 1'b0;
            w1_q     <= '0;
            m1_q     <= 1'b0;
            v2_q     <= 1'b0;
            de_q     <= 1'b0;
            data_q   <= '0;
            ctrl_q   <= '0;
        end else begin
            loss_q <= 1'b0;
            if (i_valid) begin
                prev_raw <= i_raw;
                v2_q     <= v1_q;
                if (v1_q) begin
                    de_q   <= ~m1_q;
                    data_q <= dec_data;
                    if (dec_is_ctrl) ctrl_q <= dec_ctrl;
                end
                unique case (state_q)
                    HUNT: begin
                        v1_q <= 1'b0;
                        if (!hit) begin
                            run_q <= '0;
                        end else begin
                            off_q <= hit_off;
                            run_q <= run_nx;
                            if (run_nx == RW'(CTRL_RUN)) begin
                                state_q <= LOCKED;
                                tmo_q   <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        v1_q <= 1'b1;
                        w1_q <= win_sel;
                        m1_q <= lk_hit;
                        if (lk_hit) begin
                            tmo_q <= '0;
                        end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
                            state_q <= HUNT;
                            loss_q  <= 1'b1;
                            run_q   <= '0;
                            tmo_q   <= '0;
                            v1_q    <= 1'b0;
                            v2_q    <= 1'b0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign o_valid     = v2_q & i_valid;
    assign o_de        = de_q;
    assign o_data      = data_q;
    assign o_ctrl      = ctrl_q;
    assign o_locked    = (state_q == LOCKED);
    assign o_offset    = off_q;
    assign o_lock_loss = loss_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Directed self-checking bench for tmds_rx_decoder.
module tb_tmds_rx_decoder;

    logic       i_clk;
    logic       i_rst;
    logic [9:0] i_raw;
    logic       i_valid;
    logic       o_valid;
    logic       o_de;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_locked;
    logic [3:0] o_offset;
    logic       o_lock_loss;

    tmds_rx_decoder dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_raw       (i_raw),
        .i_valid     (i_valid),
        .o_valid     (o_valid),
        .o_de        (o_de),
        .o_data      (o_data),
        .o_ctrl      (o_ctrl),
        .o_locked    (o_locked),
        .o_offset    (o_offset),
        .o_lock_loss (o_lock_loss)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [9:0] sym;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
    } vec_t;

    vec_t       tbl[12];
    int         n_pass;
    int         n_total;
    logic [9:0] pend;
    logic [9:0] tok;
    logic [9:0] dsym;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic word(input logic [9:0] raw, input logic v);
        @(negedge i_clk);
        i_raw   = raw;
        i_valid = v;
        @(posedge i_clk);
        #1;
    endtask

    // Places symbol s so that it lands in the offset-3 window
    // one accepted word later.
    task automatic send_sym(input logic [9:0] s);
        word({s[6:0], pend[9:7]}, 1'b1);
        pend = s;
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            i_raw   = 10'($urandom);
            i_valid = 1'b1;
        end
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_raw   = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int loss_at;
        int bad_valid;
        n_pass  = 0;
        n_total = 0;
        tok     = 10'b1101010100;
        dsym    = 10'b0100000000;
        i_rst   = 1'b0;
        i_raw   = '0;
        i_valid = 1'b0;

        tbl[0]  = '{10'b1101010100, 1'b0, 8'h00, 2'b00};
        tbl[1]  = '{10'b0010101011, 1'b0, 8'h00, 2'b01};
        tbl[2]  = '{10'b0101010100, 1'b0, 8'h00, 2'b10};
        tbl[3]  = '{10'b1010101011, 1'b0, 8'h00, 2'b11};
        tbl[4]  = '{10'b0100000000, 1'b1, 8'h00, 2'b11};
        tbl[5]  = '{10'b0101100011, 1'b1, 8'hA5, 2'b11};
        tbl[6]  = '{10'b1110011100, 1'b1, 8'hA5, 2'b11};
        tbl[7]  = '{10'b1000000000, 1'b1, 8'hFF, 2'b11};
        tbl[8]  = '{10'b0011111111, 1'b1, 8'hFF, 2'b11};
        tbl[9]  = '{10'b0111110000, 1'b1, 8'h10, 2'b11};
        tbl[10] = '{10'b0101010100, 1'b0, 8'h00, 2'b10};
        tbl[11] = '{10'b0111110000, 1'b1, 8'h10, 2'b10};

        // Reset held with live traffic
        repeat (3) begin
            @(negedge i_clk);
            i_raw   = 10'($urandom);
            i_valid = 1'b1;
        end
        @(posedge i_clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_de", o_de, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ctrl", o_ctrl, 0);
        chk("rst_locked", o_locked, 0);
        chk("rst_offset", o_offset, 0);
        chk("rst_loss", o_lock_loss, 0);
        @(negedge i_clk);
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_raw   = '0;

        // Lock on token stream shifted by 3
        pend = tok;
        for (int c = 1; c <= 11; c++) begin
            send_sym(tok);
            if (c == 8) chk("lock_early", o_locked, 0);
            if (c == 9) begin
                chk("lock_rise", o_locked, 1);
                chk("lock_offset", o_offset, 3);
            end
            if (c == 10) chk("lock_lat_v", o_valid, 0);
            if (c == 11) begin
                chk("lock_valid", o_valid, 1);
                chk("lock_de", o_de, 0);
                chk("lock_ctrl", o_ctrl, 0);
                chk("lock_data", o_data, 0);
            end
        end

        // Symbol decode table, two accepted words of latency
        for (int j = 0; j < 14; j++) begin
            send_sym(j < 12 ? tbl[j].sym : tok);
            if (j >= 2) begin
                chk($sformatf("tbl%0d_valid", j - 2), o_valid, 1);
                chk($sformatf("tbl%0d_de", j - 2), o_de, tbl[j-2].de);
                chk($sformatf("tbl%0d_data", j - 2), o_data, tbl[j-2].data);
                chk($sformatf("tbl%0d_ctrl", j - 2), o_ctrl, tbl[j-2].ctrl);
            end
        end

        // Timeout after 2048 token-free words
        pulses    = 0;
        loss_at   = 0;
        bad_valid = 0;
        for (int c = 1; c <= 2060; c++) begin
            send_sym(dsym);
            if (o_lock_loss) begin
                pulses++;
                loss_at = c;
            end
            if (c == 2048) chk("tmo_still_locked", o_locked, 1);
            if (c >= 2049 && o_valid) bad_valid++;
        end
        chk("tmo_pulses", pulses, 1);
        chk("tmo_loss_at", loss_at, 2049);
        chk("tmo_unlocked", o_locked, 0);
        chk("tmo_no_valid", bad_valid, 0);

        // Run broken by one data word, offset 0
        do_reset();
        for (int c = 1; c <= 18; c++) begin
            word(c == 8 ? 10'b0000000000 : tok, 1'b1);
            chk($sformatf("brk%0d_locked", c), o_locked, c >= 17);
        end
        chk("brk_offset", o_offset, 0);

        // Stalls during the lock run, then async reset mid-lock
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            word(tok, 1'b1);
            word(10'($urandom), 1'b0);
            word(10'($urandom), 1'b0);
            if (c == 8) chk("stall_early", o_locked, 0);
            if (c == 9) chk("stall_lock", o_locked, 1);
        end
        word(tok, 1'b1);
        word(tok, 1'b1);
        chk("stall_valid", o_valid, 1);
        word(10'($urandom), 1'b0);
        chk("stall_gap_valid", o_valid, 0);
        chk("stall_gap_locked", o_locked, 1);
        word(tok, 1'b1);
        chk("pre_arst_valid", o_valid, 1);
        i_rst = 1'b0;
        #1;
        chk("arst_locked", o_locked, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_offset", o_offset, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
